// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the MIPS pipeline control blocks: Tuse/Tnew codes,
// mult/div latencies and the md unit FSM states.
package cpu_ctrl_pkg;

    // Tuse: cycles until a source operand is consumed, counted from D
    localparam logic [1:0] TUSE_D    = 2'd0;
    localparam logic [1:0] TUSE_E    = 2'd1;
    localparam logic [1:0] TUSE_M    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew: cycles until a result is ready, counted from E entry
    localparam logic [1:0] TNEW_NOW  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // A producer in flight blocks a source only when it targets the same
    // non-zero register and its result arrives later than the consumer needs it.
    function automatic logic reg_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_wa,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wa,
        input logic [1:0] m_tnew
    );
        return (src != 5'd0) &&
               (((e_wa == src) && (e_tnew > tuse)) ||
                ((m_wa == src) && (m_tnew > tuse)));
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Mult/div unit sequencer: registers the start pulse as the md instruction
// enters E, then holds busy for the unit's fixed latency.
module md_busy_ctr
    import cpu_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_div,
    output logic o_E_md_start,
    output logic o_md_busy
);

    localparam logic [CNT_W-1:0] L_MULT = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] L_DIV  = CNT_W'(DIV_CYC);

    md_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div_q;

    // Start pulse, op type capture and IDLE/BUSY countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_E_md_start <= 1'b0;
            r_div_q      <= 1'b0;
            r_state      <= MD_IDLE;
            r_cnt        <= '0;
        end else begin
            o_E_md_start <= i_start;
            r_div_q      <= i_div;
            case (r_state)
                MD_IDLE: begin
                    if (o_E_md_start) begin
                        r_cnt   <= r_div_q ? L_DIV : L_MULT;
                        r_state <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    // A start in BUSY is impossible: D_md stalls every md op.
                    if (r_cnt == CNT_W'(1)) begin
                        r_cnt   <= '0;
                        r_state <= MD_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_md_busy = (r_state == MD_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS core. Tracks destination and
// Tnew of the E and M stages, compares against the D-stage sources and drives
// PC/F-D/D-E enables; also gates HI/LO users while the md unit is occupied.
module hazard_stall_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic [4:0] D_wa,
    input  logic [1:0] D_tnew,
    input  logic       D_md,
    input  logic       D_md_start,
    input  logic       D_md_div,
    output logic       stall,
    output logic       pc_en,
    output logic       fd_en,
    output logic       de_clr,
    output logic       E_md_start,
    output logic       md_busy
);

    logic [4:0] r_E_wa, r_M_wa;
    logic [1:0] r_E_tnew, r_M_tnew;
    logic       w_rs_stall, w_rt_stall, w_md_stall;

    assign w_rs_stall = reg_hazard(D_rs, D_tuse_rs, r_E_wa, r_E_tnew, r_M_wa, r_M_tnew);
    assign w_rt_stall = reg_hazard(D_rt, D_tuse_rt, r_E_wa, r_E_tnew, r_M_wa, r_M_tnew);
    assign w_md_stall = D_md & (E_md_start | md_busy);

    assign stall  = w_rs_stall | w_rt_stall | w_md_stall;
    assign pc_en  = ~stall;
    assign fd_en  = ~stall;
    assign de_clr = stall;

    // Shadow pipeline: bubble into E on stall, Tnew ages by one into M
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_E_wa   <= '0;
            r_E_tnew <= '0;
            r_M_wa   <= '0;
            r_M_tnew <= '0;
        end else begin
            r_E_wa   <= stall ? 5'd0 : D_wa;
            r_E_tnew <= stall ? TNEW_NOW : D_tnew;
            r_M_wa   <= r_E_wa;
            r_M_tnew <= (r_E_tnew == TNEW_NOW) ? TNEW_NOW : r_E_tnew - 2'd1;
        end
    end

    md_busy_ctr #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md (
        .clk          (clk),
        .rst          (rst),
        .i_start      (D_md_start & ~stall),
        .i_div        (D_md_div),
        .o_E_md_start (E_md_start),
        .o_md_busy    (md_busy)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed instruction table, async reset during
// a div, and a randomized run against a producer-age reference model.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] D_rs, D_rt, D_wa;
    logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
    logic       D_md, D_md_start, D_md_div;
    logic       stall, pc_en, fd_en, de_clr, E_md_start, md_busy;

    int n_cmp = 0;
    int n_err = 0;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .D_wa(D_wa), .D_tnew(D_tnew), .D_md(D_md), .D_md_start(D_md_start),
        .D_md_div(D_md_div), .stall(stall), .pc_en(pc_en), .fd_en(fd_en),
        .de_clr(de_clr), .E_md_start(E_md_start), .md_busy(md_busy)
    );

    typedef struct {
        int rs, rt, tr, tt, wa, tn, md, mds, mdd;
        int st, es, bz, ewa;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int rs, int rt, int tr, int tt, int wa, int tn,
                                int md, int mds, int mdd, int st, int es, int bz, int ewa);
        vec_t v;
        v.rs = rs; v.rt = rt; v.tr = tr; v.tt = tt; v.wa = wa; v.tn = tn;
        v.md = md; v.mds = mds; v.mdd = mdd;
        v.st = st; v.es = es; v.bz = bz; v.ewa = ewa;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        D_rs = 5'(v.rs); D_rt = 5'(v.rt); D_tuse_rs = 2'(v.tr); D_tuse_rt = 2'(v.tt);
        D_wa = 5'(v.wa); D_tnew = 2'(v.tn);
        D_md = v.md[0]; D_md_start = v.mds[0]; D_md_div = v.mdd[0];
    endtask

    // reference model state (random phase)
    int hist_wa[1:2];
    int hist_tn[1:2];
    int st_cyc, st_len;

    initial begin
        vec_t v, idle;
        idle = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---- directed table ----
        tbl.push_back(mk(0,0,3,3,2,2, 0,0,0, 0,0,0,0));   // lw $2
        tbl.push_back(mk(2,0,1,3,3,1, 0,0,0, 1,0,0,2));   // addu rs=$2 tuse 1
        tbl.push_back(mk(2,0,1,3,3,1, 0,0,0, 0,0,0,0));   //   advances, bubble in E
        tbl.push_back(mk(0,0,3,3,2,2, 0,0,0, 0,0,0,3));   // lw $2
        for (int i = 0; i < 3; i++)                       // beq rs=$2 tuse 0
            tbl.push_back(mk(2,0,0,3,0,0, 0,0,0, (i < 2) ? 1 : 0, 0, 0, (i == 0) ? 2 : 0));
        tbl.push_back(mk(0,0,3,3,0,1, 0,0,0, 0,0,0,0));   // addu writing $0
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0));   // rs=rt=0 tuse 0
        tbl.push_back(mk(0,0,3,3,5,2, 0,0,0, 0,0,0,0));   // lw $5
        tbl.push_back(mk(5,5,3,3,0,0, 0,0,0, 0,0,0,5));   // tuse 3, matching reg
        tbl.push_back(mk(0,0,3,3,6,2, 0,0,0, 0,0,0,0));   // lw $6
        tbl.push_back(mk(0,6,3,1,0,0, 0,0,0, 1,0,0,6));   // rt=$6 tuse 1
        tbl.push_back(mk(0,6,3,1,0,0, 0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,3,3,0,0, 1,1,0, 0,0,0,0));   // mult
        tbl.push_back(mk(0,0,3,3,7,1, 1,0,0, 1,1,0,0));   // mfhi
        for (int i = 0; i < MULT_CYC; i++)
            tbl.push_back(mk(0,0,3,3,7,1, 1,0,0, 1,0,1,0));
        tbl.push_back(mk(0,0,3,3,7,1, 1,0,0, 0,0,0,0));   // mfhi advances on 7th
        tbl.push_back(mk(0,0,3,3,0,0, 1,1,1, 0,0,0,7));   // div
        tbl.push_back(mk(0,0,3,3,0,1, 1,0,0, 1,1,0,0));   // mflo
        for (int i = 0; i < DIV_CYC; i++)
            tbl.push_back(mk(0,0,3,3,0,1, 1,0,0, 1,0,1,0));
        tbl.push_back(mk(0,0,3,3,0,1, 1,0,0, 0,0,0,0));   // mflo advances on 12th

        rst = 1'b1;
        drive(idle);
        #2;
        chk("reset_stall", stall, 0);
        chk("reset_busy", md_busy, 0);
        chk("reset_start", E_md_start, 0);
        chk("reset_pc_en", pc_en, 1);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("row%0d_stall", i), stall, tbl[i].st);
            chk($sformatf("row%0d_start", i), E_md_start, tbl[i].es);
            chk($sformatf("row%0d_busy", i), md_busy, tbl[i].bz);
            chk($sformatf("row%0d_E_wa", i), dut.r_E_wa, tbl[i].ewa);
            chk($sformatf("row%0d_en", i), {pc_en, fd_en, de_clr}, {~tbl[i].st[0], ~tbl[i].st[0], tbl[i].st[0]});
            @(posedge clk); #1;
        end

        // ---- async reset on the 3rd busy cycle of a div ----
        drive(mk(0,0,3,3,0,0, 1,1,1, 0,0,0,0));          // div
        @(negedge clk);
        chk("rstseq_div_stall", stall, 0);
        @(posedge clk); #1;
        drive(mk(0,0,3,3,9,1, 0,0,0, 0,0,0,0));          // non-md filler writing $9
        for (int i = 0; i < 3; i++) begin                // start cycle, busy 1, busy 2
            @(posedge clk); #1;
        end
        D_md = 1'b1;                                      // busy 3: HI/LO user in D
        #1;
        chk("rstseq_pre_busy", md_busy, 1);
        chk("rstseq_pre_stall", stall, 1);
        chk("rstseq_pre_E_wa", dut.r_E_wa, 9);
        rst = 1'b1;
        #1;
        chk("rstseq_busy", md_busy, 0);
        chk("rstseq_stall", stall, 0);
        chk("rstseq_start", E_md_start, 0);
        chk("rstseq_E_wa", dut.r_E_wa, 0);
        chk("rstseq_M_wa", dut.r_M_wa, 0);
        drive(idle);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rstseq_post_start", E_md_start, 0);
            chk("rstseq_post_busy", md_busy, 0);
        end

        // ---- randomized run against the reference model ----
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        hist_wa[1] = 0; hist_wa[2] = 0; hist_tn[1] = 0; hist_tn[2] = 0;
        st_cyc = -100; st_len = 0;
        for (int c = 0; c < 2000; c++) begin
            int e_start, e_busy, e_stall, rem;
            v.rs = $urandom_range(0, 3); v.rt = $urandom_range(0, 3);
            v.tr = $urandom_range(0, 3); v.tt = $urandom_range(0, 3);
            v.wa = $urandom_range(0, 3); v.tn = $urandom_range(0, 2);
            v.mds = ($urandom_range(0, 7) == 0) ? 1 : 0;
            v.md  = (v.mds == 1 || $urandom_range(0, 3) == 0) ? 1 : 0;
            v.mdd = $urandom_range(0, 1);
            drive(v);

            // producer that left D k cycles ago has max(tnew-(k-1),0) cycles to go
            e_start = (c == st_cyc + 1) ? 1 : 0;
            e_busy  = (c >= st_cyc + 2 && c <= st_cyc + 1 + st_len) ? 1 : 0;
            e_stall = (v.md == 1 && (e_start == 1 || e_busy == 1)) ? 1 : 0;
            for (int k = 1; k <= 2; k++) begin
                rem = hist_tn[k] - (k - 1);
                if (rem < 0) rem = 0;
                if (v.rs != 0 && hist_wa[k] == v.rs && rem > v.tr) e_stall = 1;
                if (v.rt != 0 && hist_wa[k] == v.rt && rem > v.tt) e_stall = 1;
            end

            @(negedge clk);
            chk("rnd_stall", stall, e_stall);
            chk("rnd_start", E_md_start, e_start);
            chk("rnd_busy", md_busy, e_busy);
            @(posedge clk); #1;

            hist_wa[2] = hist_wa[1]; hist_tn[2] = hist_tn[1];
            hist_wa[1] = (e_stall == 1) ? 0 : v.wa;
            hist_tn[1] = (e_stall == 1) ? 0 : v.tn;
            if (v.mds == 1 && e_stall == 0) begin
                st_cyc = c;
                st_len = (v.mdd == 1) ? DIV_CYC : MULT_CYC;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage MIPS core. It keeps a shadow pipeline of destination register and Tnew for the E and M stages, and compares it against the D-stage instruction's source registers and Tuse. From that it drives the stall and clear controls of the PC, F/D and D/E pipeline registers. It also sequences the multi-cycle mult/div unit (start pulse, busy counter) and stalls HI/LO-dependent instructions in D while that unit is occupied.

Parameters:
MULT_CYC, 5, busy cycles for mult/multu after start
DIV_CYC, 10, busy cycles for div/divu after start
CNT_W, 4, busy counter width; must satisfy 2^CNT_W > max(MULT_CYC, DIV_CYC)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
D_rs  in  5  D-stage rs field
D_rt  in  5  D-stage rt field
D_tuse_rs  in  2  cycles until rs is needed (0=D, 1=E, 2=M, 3=unused)
D_tuse_rt  in  2  same encoding, for rt
D_wa  in  5  D-stage destination register (0 = no write)
D_tnew  in  2  cycles until result is ready, counted from E entry (ALU=1, lw=2, jal=0)
D_md  in  1  D instruction uses HI/LO or the md unit (mult*, div*, mfhi/lo, mthi/lo)
D_md_start  in  1  D instruction is mult/multu/div/divu
D_md_div  in  1  qualifies D_md_start: 1=div, 0=mult
stall  out  1  freeze PC and F/D; clear D/E
pc_en  out  1  equals ~stall
fd_en  out  1  equals ~stall
de_clr  out  1  equals stall
E_md_start  out  1  one-cycle start pulse to the md unit; high while the md instruction is in E
md_busy  out  1  md unit is occupied

Behaviour:
- Reset is asynchronous. All state clears immediately: E_wa, E_tnew, M_wa, M_tnew, E_md_start, the busy counter, and the md FSM (to IDLE).
- After reset, stall=0, md_busy=0 and E_md_start=0.
- Shadow pipeline, updated on every posedge clk:
  - If stall=0: E_wa<=D_wa and E_tnew<=D_tnew.
  - If stall=1: a bubble is loaded, E_wa<=0 and E_tnew<=0.
  - Always: M_wa<=E_wa and M_tnew<=(E_tnew==0 ? 0 : E_tnew-1). The subtraction saturates at 0.
  - The W stage is not tracked; its Tnew is always 0.
- Register hazard for rs, which is purely combinational:
  - rs_stall = D_rs!=0 AND ((E_wa==D_rs AND E_tnew>D_tuse_rs) OR (M_wa==D_rs AND M_tnew>D_tuse_rs)).
  - Tuse=3 therefore never stalls.
  - rt_stall is defined identically using D_rt and D_tuse_rt.
- md hazard: md_stall = D_md AND (E_md_start OR md_busy).
- stall = rs_stall OR rt_stall OR md_stall.
- md FSM, states IDLE and BUSY:
  - E_md_start <= D_md_start AND ~stall. It is registered and lasts exactly one cycle per instruction.
  - IDLE, when E_md_start=1: load cnt<=(E_div_q ? DIV_CYC : MULT_CYC) and go to BUSY. E_div_q is D_md_div registered alongside E_md_start.
  - BUSY: cnt decrements each cycle. When cnt==1 at a clock edge, go to IDLE and set cnt<=0.
  - md_busy = (state==BUSY). It is high for exactly MULT_CYC or DIV_CYC cycles.
- A new start cannot arrive while E_md_start or md_busy is set, because D_md covers every start instruction. The FSM ignores E_md_start in BUSY.
- Simultaneous events: a register hazard and an md hazard on the same cycle produce a single stall. The instruction is held in D until both conditions clear.
- Reset mid-busy: busy drops asynchronously and no start pulse is issued afterwards.

Decomposition:
- Shared package (cpu_ctrl_pkg) holds:
  - the TUSE_* and TNEW_* encodings, including TUSE_NONE=3;
  - the MULT_CYC and DIV_CYC defaults;
  - the md FSM state constants.
- One sub-module: md_busy_ctr. It contains the IDLE/BUSY FSM, the counter, and E_md_start/E_div_q.
- Hazard compare and shadow pipeline stay in the top level.

Test Plan:
- lw $2 (D_wa=2, D_tnew=2), then addu with rs=2, tuse_rs=1 -> stall=1 for exactly 1 cycle; E_wa=0 (bubble) the following cycle.
- lw $2, then beq with rs=2, tuse_rs=0 -> stall for 2 consecutive cycles, then 0.
- addu writing $0, then use of rs=0 with tuse=0 -> stall never asserts; same for a consumer with tuse=3 and a matching register.
- mult (D_md_start=1, D_md_div=0), then mfhi (D_md=1):
  - E_md_start high for 1 cycle, then md_busy high for 5 cycles;
  - mfhi stalls for 6 cycles and advances on the 7th.
- div, then mflo -> md_busy high for 10 cycles; mflo stalls for 11 cycles.
- Assert rst asynchronously at the 3rd busy cycle of a div -> md_busy, stall and E_md_start read 0 before the next clk edge; E_wa and M_wa read 0.
